// File: rtl/fetch_ctrl_pkg.sv
// Shared fetch-controller types and defaults: FSM state codes and the boot PC.
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_ADDR_W     = 32;
    localparam logic [31:0] FETCH_RESET_PC   = 32'h0000_3000;

    typedef enum logic [1:0] {
        FETCH_BOOT  = 2'd0,
        FETCH_ISSUE = 2'd1,
        FETCH_WAIT  = 2'd2,
        FETCH_DROP  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Architectural PC owner: issues one-outstanding imem fetches, fills the IF/ID
// slot under decode backpressure and applies npc-unit redirects.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = FETCH_RESET_PC,
    parameter int unsigned ADDR_W   = FETCH_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic              if_valid,
    output logic [ADDR_W-1:0] if_pc,
    output logic [31:0]       if_instr
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              accept;

    assign imem_addr = pc;

    // Request is held until completion in WAIT/DROP; ISSUE holds off only on a full, stalled slot.
    always_comb begin
        imem_req = 1'b0;
        accept   = 1'b0;
        case (state)
            FETCH_BOOT:  imem_req = 1'b0;
            FETCH_ISSUE: imem_req = !(if_valid && stall);
            FETCH_WAIT:  imem_req = 1'b1;
            FETCH_DROP:  imem_req = 1'b1;
            default:     imem_req = 1'b0;
        endcase
        accept = imem_req && imem_ready && !redir_valid &&
                 ((state == FETCH_ISSUE) || (state == FETCH_WAIT));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH_BOOT;
            pc       <= ADDR_W'(RESET_PC);
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_instr <= '0;
        end else if (redir_valid) begin
            // Flush the slot; an uncompleted outstanding request must be waited out in DROP.
            pc       <= redir_pc & ~ADDR_W'(3);
            if_valid <= 1'b0;
            if (((state == FETCH_WAIT) || (state == FETCH_DROP)) && !imem_ready) begin
                state <= FETCH_DROP;
            end else begin
                state <= FETCH_ISSUE;
            end
        end else if (accept) begin
            if_pc    <= pc;
            if_instr <= imem_rdata;
            if_valid <= 1'b1;
            pc       <= pc + ADDR_W'(4);
            state    <= FETCH_ISSUE;
        end else begin
            if (if_valid && !stall) begin
                if_valid <= 1'b0;
            end
            case (state)
                FETCH_BOOT:  state <= FETCH_ISSUE;
                FETCH_ISSUE: if (imem_req) state <= FETCH_WAIT;
                FETCH_WAIT:  state <= FETCH_WAIT;
                FETCH_DROP:  if (imem_ready) state <= FETCH_ISSUE;
                default:     state <= FETCH_BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: boot, stall, redirect during wait/ready, async reset, wrap.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    logic        zero_lat;
    logic        rdy_drv;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [31:0] TAG = 32'hA5A5_0000;

    always #5 clk = ~clk;

    assign imem_ready = zero_lat ? imem_req : rdy_drv;
    assign imem_rdata = imem_addr ^ TAG;

    fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redir_valid = 1'b0; redir_pc = '0;
        zero_lat = 1'b1; rdy_drv = 1'b0;
        #22;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%0b exp=0", if_valid); end
        n_cmp++; if (if_pc !== 32'h0) begin n_err++; $display("FAIL rst_if_pc got=%h exp=00000000", if_pc); end
        n_cmp++; if (if_instr !== 32'h0) begin n_err++; $display("FAIL rst_if_instr got=%h exp=00000000", if_instr); end
        n_cmp++; if (imem_addr !== 32'h3000) begin n_err++; $display("FAIL rst_addr got=%h exp=00003000", imem_addr); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req got=%0b exp=0", imem_req); end
        tick();
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL issue_req got=%0b exp=1", imem_req); end
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL issue_valid got=%0b exp=0", if_valid); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'h3000 + 32'(4 * i) ||
                if_instr !== ((32'h3000 + 32'(4 * i)) ^ TAG)) begin
                n_err++;
                $display("FAIL stream%0d got v=%0b pc=%h ins=%h exp v=1 pc=%h", i, if_valid, if_pc, if_instr,
                         32'h3000 + 32'(4 * i));
            end
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req got=%0b exp=0", imem_req); end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if (if_valid !== 1'b1 || if_pc !== 32'h3008 || if_instr !== (32'h3008 ^ TAG) || imem_req !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold%0d got v=%0b pc=%h ins=%h req=%0b exp v=1 pc=00003008 req=0",
                         i, if_valid, if_pc, if_instr, imem_req);
            end
        end
        stall = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h300C) begin n_err++; $display("FAIL stall_rel0 got v=%0b pc=%h exp v=1 pc=0000300c", if_valid, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3010) begin n_err++; $display("FAIL stall_rel1 got v=%0b pc=%h exp v=1 pc=00003010", if_valid, if_pc); end
    endtask

    task automatic test_redirect_wait();
        zero_lat = 1'b0; rdy_drv = 1'b0;
        tick();
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'h3014 || imem_req !== 1'b1) begin n_err++; $display("FAIL wait_enter got v=%0b addr=%h req=%0b exp v=0 addr=00003014 req=1", if_valid, imem_addr, imem_req); end
        redir_valid = 1'b1; redir_pc = 32'h3400;
        tick();
        redir_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'h3400 || imem_req !== 1'b1 || if_valid !== 1'b0) begin n_err++; $display("FAIL drop_enter got addr=%h req=%0b v=%0b exp addr=00003400 req=1 v=0", imem_addr, imem_req, if_valid); end
        rdy_drv = 1'b1;
        tick();
        rdy_drv = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL drop_discard got v=%0b exp v=0", if_valid); end
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3400) begin n_err++; $display("FAIL drop_next got req=%0b addr=%h exp req=1 addr=00003400", imem_req, imem_addr); end
        rdy_drv = 1'b1;
        tick();
        rdy_drv = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3400 || if_instr !== (32'h3400 ^ TAG)) begin n_err++; $display("FAIL redir_fetch got v=%0b pc=%h ins=%h exp v=1 pc=00003400", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_redirect_ready();
        rdy_drv = 1'b1; redir_valid = 1'b1; redir_pc = 32'h3100;
        tick();
        redir_valid = 1'b0; rdy_drv = 1'b0;
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL rr_flush got v=%0b exp v=0", if_valid); end
        n_cmp++; if (imem_addr !== 32'h3100) begin n_err++; $display("FAIL rr_addr got=%h exp=00003100", imem_addr); end
        zero_lat = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3100) begin n_err++; $display("FAIL rr_fetch got v=%0b pc=%h exp v=1 pc=00003100", if_valid, if_pc); end
    endtask

    task automatic test_reset_mid_wait();
        zero_lat = 1'b0; rdy_drv = 1'b0;
        tick();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h3104) begin n_err++; $display("FAIL mw_wait got req=%0b addr=%h exp req=1 addr=00003104", imem_req, imem_addr); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_addr !== 32'h3000 || imem_req !== 1'b0) begin
            n_err++;
            $display("FAIL mw_async got v=%0b pc=%h ins=%h addr=%h req=%0b exp v=0 pc=0 ins=0 addr=00003000 req=0",
                     if_valid, if_pc, if_instr, imem_addr, imem_req);
        end
        rdy_drv = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        n_cmp++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL mw_stray got v=%0b exp v=0", if_valid); end
        tick();
        rdy_drv = 1'b0;
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h3000) begin n_err++; $display("FAIL mw_refetch got v=%0b pc=%h exp v=1 pc=00003000", if_valid, if_pc); end
    endtask

    task automatic test_wrap();
        zero_lat = 1'b1;
        redir_valid = 1'b1; redir_pc = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        n_cmp++; if (if_valid !== 1'b0 || imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_redir got v=%0b addr=%h exp v=0 addr=fffffffc", if_valid, imem_addr); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top got v=%0b pc=%h exp v=1 pc=fffffffc", if_valid, if_pc); end
        tick();
        n_cmp++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_zero got v=%0b pc=%h exp v=1 pc=00000000", if_valid, if_pc); end
        redir_valid = 1'b1; redir_pc = 32'h0000_3203;
        tick();
        redir_valid = 1'b0;
        n_cmp++; if (imem_addr !== 32'h0000_3200) begin n_err++; $display("FAIL align got=%h exp=00003200", imem_addr); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_wait();
        test_redirect_ready();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
